demux1x2_stream: RTL

- Stream demultiplexer: steers a valid/ready data stream from one input to one of two outputs.
- The output is chosen by `sel`, sampled on the first beat of each packet and locked until the beat carrying `in_last`.
- Each output has its own one-entry output register, so an idle or stalled output never blocks a packet routed to the other output.
- Sits downstream of a single producer and fans out to two consumers. It is the splitting counterpart of the 2:1 selection used elsewhere in the datapath.

---
 rtl/demux1x2_stream.sv | 122 ++++++++++++
 1 files changed

// File: rtl/demux1x2_stream.sv
// 1:2 valid/ready stream demultiplexer with per-packet routing and one-entry output registers.
// Optional per-output beat counters are enabled by defining DEMUX_BEAT_CNT_EN.
module demux1x2_stream #(
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out0_valid,
  output logic [DW-1:0] out0_data,
  output logic          out0_last,
  input  logic          out0_ready,
  output logic          out1_valid,
  output logic [DW-1:0] out1_data,
  output logic          out1_last,
  input  logic          out1_ready,
  output logic          busy
`ifdef DEMUX_BEAT_CNT_EN
  ,
  output logic [15:0]   out0_cnt,
  output logic [15:0]   out1_cnt
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          route_q, route_d;
  logic          target;
  logic          accept;
  logic [1:0]    oready;
  logic [1:0]    drain;
  logic [1:0]    ovalid_q;
  logic [1:0]    olast_q;
  logic [DW-1:0] odata_q [2];

  assign oready = {out1_ready, out0_ready};

  // Destination follows sel only between packets; mid-packet it is pinned to route.
  always_comb begin
    target   = (state_q == LOCK) ? route_q : sel;
    in_ready = ~ovalid_q[target] | oready[target];
    accept   = in_valid & in_ready;
  end

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    if (accept) begin
      if (state_q == IDLE) begin
        route_d = sel;
      end
      state_d = in_last ? IDLE : LOCK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      route_q <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_out
      assign drain[gi] = ovalid_q[gi] & oready[gi];

      // A load in the same cycle as a drain wins, keeping one beat per cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovalid_q[gi] <= 1'b0;
          odata_q[gi]  <= '0;
          olast_q[gi]  <= 1'b0;
        end else if (accept && (target == 1'(gi))) begin
          ovalid_q[gi] <= 1'b1;
          odata_q[gi]  <= in_data;
          olast_q[gi]  <= in_last;
        end else if (drain[gi]) begin
          ovalid_q[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign out0_valid = ovalid_q[0];
  assign out0_data  = odata_q[0];
  assign out0_last  = olast_q[0];
  assign out1_valid = ovalid_q[1];
  assign out1_data  = odata_q[1];
  assign out1_last  = olast_q[1];
  assign busy       = (state_q == LOCK);

`ifdef DEMUX_BEAT_CNT_EN
  logic [15:0] cnt_q [2];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      // Saturating handshake counter, cleared only by reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q[gi] <= '0;
        end else if (drain[gi] && (cnt_q[gi] != 16'hFFFF)) begin
          cnt_q[gi] <= cnt_q[gi] + 16'd1;
        end
      end
    end
  endgenerate

  assign out0_cnt = cnt_q[0];
  assign out1_cnt = cnt_q[1];
`endif

endmodule
